// File: rtl/video_timing_gol.sv
// 720p video timing generator with a Game of Life step-request handshake.
// Optional macro STEP_DIV_EN: one step per step_div+1 frames instead of every frame.
module video_timing_gol #(
  parameter int SYNC_DELAY   = 2,  // 1..4
  parameter int STEP_DIV_W   = 8,
  parameter int H_ACTIVE     = 1280,
  parameter int H_SYNC_START = 1390,
  parameter int H_SYNC_END   = 1430,
  parameter int H_TOTAL      = 1650,
  parameter int V_ACTIVE     = 720,
  parameter int V_SYNC_START = 725,
  parameter int V_SYNC_END   = 730,
  parameter int V_TOTAL      = 750
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [11:0]           pixel_x,
  output logic [11:0]           pixel_y,
  output logic                  de,
  output logic                  de_o,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  frame_start,
  input  logic [STEP_DIV_W-1:0] step_div,
  output logic                  step_req,
  input  logic                  step_ack,
  output logic [7:0]            overrun_cnt
);

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] H_SS   = 12'(H_SYNC_START);
  localparam logic [11:0] H_SE   = 12'(H_SYNC_END);
  localparam logic [11:0] V_SS   = 12'(V_SYNC_START);
  localparam logic [11:0] V_SE   = 12'(V_SYNC_END);

  logic [11:0] next_x;
  logic [11:0] next_y;
  logic        hsync;
  logic        vsync;
  logic        blank_start;
  logic        step_evt;

  always_comb begin
    next_x = pixel_x + 12'd1;
    next_y = pixel_y;
    if (pixel_x == H_LAST) begin
      next_x = '0;
      next_y = (pixel_y == V_LAST) ? '0 : pixel_y + 12'd1;
    end
  end

  // Every timing output is decoded from the next-state counters so it lines up with them.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_x     <= H_LAST;
      pixel_y     <= V_LAST;
      de          <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_x     <= next_x;
      pixel_y     <= next_y;
      de          <= (next_x < H_ACT) && (next_y < V_ACT);
      hsync       <= (next_x >= H_SS) && (next_x < H_SE);
      vsync       <= (next_y >= V_SS) && (next_y < V_SE);
      frame_start <= (next_x == 12'd0) && (next_y == 12'd0);
    end
  end

  logic [2:0] sync_pipe [SYNC_DELAY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_DELAY; i++) sync_pipe[i] <= '0;
    end else begin
      sync_pipe[0] <= {de, hsync, vsync};
      for (int i = 1; i < SYNC_DELAY; i++) sync_pipe[i] <= sync_pipe[i-1];
    end
  end

  assign {de_o, hsync_o, vsync_o} = sync_pipe[SYNC_DELAY-1];

  assign blank_start = (pixel_x == 12'd0) && (pixel_y == V_ACT);

`ifdef STEP_DIV_EN
  logic [STEP_DIV_W-1:0] div_cnt;
  logic                  div_hit;

  // >= rather than == so a step_div lowered below the count fires at the next blank.
  assign div_hit = (div_cnt >= step_div);

  always_ff @(posedge clk) begin
    if (rst)              div_cnt <= '0;
    else if (blank_start) div_cnt <= div_hit ? '0 : div_cnt + STEP_DIV_W'(1);
  end

  assign step_evt = blank_start && div_hit;
`else
  logic unused_step_div;
  assign unused_step_div = ^step_div;
  assign step_evt        = blank_start;
`endif

  // step_req: valid-style request, held until step_ack is sampled high; ack while idle is ignored.
  typedef enum logic {S_IDLE, S_REQ} hs_state_t;
  hs_state_t state, state_nxt;
  logic      overrun_inc;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    overrun_inc = 1'b0;
    case (state)
      S_IDLE: if (step_evt) state_nxt = S_REQ;
      S_REQ: begin
        if (step_evt) overrun_inc = !step_ack;
        else if (step_ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign step_req = (state == S_REQ);

  always_ff @(posedge clk) begin
    if (rst)                                     overrun_cnt <= '0;
    else if (overrun_inc && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
  end

endmodule
